// File: rtl/load_store_unit.sv
// Load/store unit: turns one sized, possibly signed memory request into a single
// aligned memory-port access and returns an extended result or an error code.
module load_store_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int ENDIAN_SWAP = 1,
  parameter int TIMEOUT     = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_store,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [1:0]          resp_err,
  output logic                mem_en,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_done
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                store_q, uns_q;
  logic [1:0]          size_q, err_q, req_err;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [CNT_W-1:0]    cnt;
  logic [OFF_W-1:0]    off;
  logic [2:0]          align_mask;
  logic                accept, timeout_hit, sign_bit;
  logic [BYTES-1:0]    size_mask, we_raw;
  logic [DATA_W-1:0]   wdata_raw, rdata_sw, field, load_result;

  function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = d[8*(BYTES-1-i) +: 8];
    return r;
  endfunction

  function automatic logic [BYTES-1:0] bit_rev(input logic [BYTES-1:0] d);
    logic [BYTES-1:0] r;
    r = '0;
    for (int i = 0; i < BYTES; i++) r[i] = d[BYTES-1-i];
    return r;
  endfunction

  assign accept      = req_valid && (state == IDLE);
  assign off         = addr_q[OFF_W-1:0];
  assign timeout_hit = (state == WAIT) && !mem_done && (cnt == CNT_W'(TIMEOUT));

  // Illegal size outranks misalignment.
  always_comb begin
    align_mask = 3'b111;
    case (req_size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    if (req_size == 2'd3 && DATA_W == 32) req_err = 2'd3;
    else if (|(req_addr[2:0] & align_mask)) req_err = 2'd1;
    else req_err = 2'd0;
  end

  always_comb begin
    size_mask = '0;
    for (int i = 0; i < BYTES; i++) size_mask[i] = (i < (1 << size_q));
    we_raw    = store_q ? (size_mask << off) : '0;
    wdata_raw = wdata_q << {off, 3'b000};
  end

  // Lane-select after the optional swap, then sign or zero extend.
  always_comb begin
    rdata_sw = (ENDIAN_SWAP != 0) ? byte_rev(mem_rdata) : mem_rdata;
    field    = rdata_sw >> {off, 3'b000};
    case (size_q)
      2'd0:    sign_bit = field[7];
      2'd1:    sign_bit = field[15];
      2'd2:    sign_bit = field[31];
      default: sign_bit = field[DATA_W-1];
    endcase
    load_result = '0;
    for (int i = 0; i < DATA_W; i++)
      load_result[i] = (i < (8 << size_q)) ? field[i] : (sign_bit & ~uns_q);
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (req_err == 2'd0) ? ISSUE : RESP;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (mem_done || timeout_hit) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (accept) begin
            store_q <= req_store;
            uns_q   <= req_unsigned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_err;
          end
        end
        ISSUE: cnt <= CNT_W'(1);
        WAIT: begin
          if (mem_done) begin
            err_q   <= 2'd0;
            rdata_q <= store_q ? '0 : load_result;
          end else if (timeout_hit) begin
            err_q <= 2'd2;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = '0;
    mem_en     = 1'b0;
    mem_addr   = '0;
    mem_we     = '0;
    mem_wdata  = '0;
    if (rstn) begin
      case (state)
        IDLE:  req_ready = 1'b1;
        ISSUE: begin
          mem_en    = 1'b1;
          mem_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          mem_we    = (ENDIAN_SWAP != 0) ? bit_rev(we_raw) : we_raw;
          mem_wdata = (ENDIAN_SWAP != 0) ? byte_rev(wdata_raw) : wdata_raw;
        end
        RESP: begin
          resp_valid = 1'b1;
          resp_data  = rdata_q;
          resp_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: a plain-endian and a byte-swapped instance
// share all inputs and are checked against a byte-lane memory model.
module tb_load_store_unit;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        resp_ready = 1'b0, mem_done = 1'b0;

  logic        req_ready, resp_valid, mem_en;
  logic [31:0] resp_data, mem_addr, mem_wdata;
  logic [1:0]  resp_err;
  logic [3:0]  mem_we;
  logic        req_ready_s, resp_valid_s, mem_en_s;
  logic [31:0] resp_data_s, mem_addr_s, mem_wdata_s;
  logic [1:0]  resp_err_s;
  logic [3:0]  mem_we_s;

  int total = 0, bad = 0;
  int lastLat, lastPulses;
  logic [31:0] lastAddr, lastWdata, lastWdataS, lastResp, lastRespS;
  logic [3:0]  lastWe, lastWeS;
  logic [1:0]  lastErr;

  load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ENDIAN_SWAP(0), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done));

  load_store_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ENDIAN_SWAP(1), .TIMEOUT(TIMEOUT)) dut_sw (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready_s),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_s),
    .resp_ready(resp_ready), .resp_data(resp_data_s), .resp_err(resp_err_s),
    .mem_en(mem_en_s), .mem_addr(mem_addr_s), .mem_we(mem_we_s), .mem_wdata(mem_wdata_s),
    .mem_rdata(mem_rdata), .mem_done(mem_done));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: memory is four byte lanes; lane i holds address offset i,
  // or offset 3-i when the port is byte-swapped.
  function automatic logic [1:0] expErr(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'd3) return 2'd3;
    if ((ad % (32'd1 << sz)) != 0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] expLoad(input logic [31:0] rd, input logic [1:0] sz,
                                          input logic un, input logic [31:0] ad, input bit sw);
    logic [7:0] lanes [4];
    longint val;
    int n, off;
    n = 1 << sz;
    off = int'(ad % 4);
    val = 0;
    for (int i = 0; i < 4; i++) lanes[i] = sw ? rd[8*(3-i) +: 8] : rd[8*i +: 8];
    for (int k = 0; k < n; k++) val = val | (longint'(lanes[off+k]) << (8*k));
    if (!un && ((val >> (8*n-1)) & 1) == 1) val = val - (longint'(1) << (8*n));
    return val[31:0];
  endfunction

  function automatic logic [3:0] expWe(input logic [1:0] sz, input logic [31:0] ad, input bit sw);
    logic [3:0] r;
    int n, off;
    n = 1 << sz;
    off = int'(ad % 4);
    r = '0;
    for (int b = 0; b < 4; b++) if (b >= off && b < off + n) r[sw ? 3-b : b] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] expWdata(input logic [31:0] wd, input logic [31:0] ad, input bit sw);
    logic [31:0] r;
    int off;
    off = int'(ad % 4);
    r = '0;
    for (int b = 0; b < 4; b++) if (b >= off) r[8*(sw ? 3-b : b) +: 8] = wd[8*(b-off) +: 8];
    return r;
  endfunction

  task automatic checkResetOutputs();
    checkOutput("rst_req_ready", {req_ready, req_ready_s}, 0);
    checkOutput("rst_resp_valid", {resp_valid, resp_valid_s}, 0);
    checkOutput("rst_resp_data", {resp_data, resp_data_s}, 0);
    checkOutput("rst_resp_err", {resp_err, resp_err_s}, 0);
    checkOutput("rst_mem_en", {mem_en, mem_en_s}, 0);
    checkOutput("rst_mem_addr", {mem_addr, mem_addr_s}, 0);
    checkOutput("rst_mem_we", {mem_we, mem_we_s}, 0);
    checkOutput("rst_mem_wdata", {mem_wdata, mem_wdata_s}, 0);
  endtask

  // doneAt = WAIT cycle on which mem_done is raised, 0 = never.
  task automatic applyStimulus(input logic st, input logic [1:0] sz, input logic un,
                               input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] rd,
                               input int doneAt, input int hold, input logic spur);
    int k, lat, waitN, pulses;
    bit seen;
    logic [1:0] aErr, eErr;
    logic [31:0] eData, eDataS;
    aErr = expErr(sz, ad);
    eErr = (aErr == 0 && doneAt == 0) ? 2'd2 : aErr;
    eData  = (eErr == 0 && !st) ? expLoad(rd, sz, un, ad, 0) : 32'd0;
    eDataS = (eErr == 0 && !st) ? expLoad(rd, sz, un, ad, 1) : 32'd0;
    k = 0;
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    checkOutput("idle_ready", req_ready, 1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = un;
    req_addr = ad; req_wdata = wd; mem_done = 1'b0; resp_ready = 1'b0;
    @(negedge clk);
    req_store = $urandom_range(0, 1); req_size = $urandom_range(0, 3);
    req_unsigned = $urandom_range(0, 1); req_addr = $urandom; req_wdata = $urandom;
    mem_done = spur;
    lat = 1; waitN = 0; pulses = 0; seen = 0;
    while (!resp_valid && lat < 40) begin
      checkOutput("busy_ready", req_ready, 0);
      if (mem_en) begin
        pulses++;
        seen = 1;
        checkOutput("issue_sync", mem_en_s, 1);
        lastAddr = mem_addr; lastWe = mem_we; lastWdata = mem_wdata;
        lastWeS = mem_we_s; lastWdataS = mem_wdata_s;
        mem_done = spur;
        mem_rdata = $urandom;
      end else if (seen) begin
        waitN++;
        mem_done = (waitN == doneAt);
        mem_rdata = (waitN == doneAt) ? rd : $urandom;
      end
      @(negedge clk);
      lat++;
    end
    mem_done = 1'b0;
    lastLat = lat; lastPulses = pulses;
    lastResp = resp_data; lastRespS = resp_data_s; lastErr = resp_err;
    checkOutput("resp_valid", {resp_valid, resp_valid_s}, 2'b11);
    if (aErr != 0) begin
      checkOutput("err_latency_le2", lat <= 2, 1);
      checkOutput("err_no_access", pulses, 0);
    end else begin
      checkOutput("latency", lat, 2 + (doneAt == 0 ? TIMEOUT : doneAt));
      checkOutput("access_pulses", pulses, 1);
      checkOutput("mem_addr", lastAddr, ad & ~32'd3);
      checkOutput("mem_we", lastWe, st ? expWe(sz, ad, 0) : 4'd0);
      checkOutput("mem_we_swap", lastWeS, st ? expWe(sz, ad, 1) : 4'd0);
      if (st) begin
        checkOutput("mem_wdata", lastWdata, expWdata(wd, ad, 0));
        checkOutput("mem_wdata_swap", lastWdataS, expWdata(wd, ad, 1));
      end
    end
    checkOutput("resp_err", {resp_err, resp_err_s}, {eErr, eErr});
    checkOutput("resp_data", resp_data, eData);
    checkOutput("resp_data_swap", resp_data_s, eDataS);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_valid", {resp_valid, resp_valid_s}, 2'b11);
      checkOutput("hold_err", {resp_err, resp_err_s}, {eErr, eErr});
      checkOutput("hold_data", {resp_data, resp_data_s}, {eData, eDataS});
    end
    resp_ready = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    checkOutput("after_resp_valid", {resp_valid, resp_valid_s}, 0);
    checkOutput("after_resp_ready", {req_ready, req_ready_s}, 2'b11);
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic st, un, sp;
    logic [1:0] sz;
    logic [31:0] ad;
    int dn;

    repeat (3) @(negedge clk);
    checkResetOutputs();
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("first_ready", {req_ready, req_ready_s}, 2'b11);

    // sb at 0x1003
    applyStimulus(1, 0, 0, 32'h1003, 32'h000000AB, 32'h0, 1, 0, 0);
    checkOutput("sb_addr", lastAddr, 32'h1000);
    checkOutput("sb_we", lastWe, 4'b1000);
    checkOutput("sb_wdata", lastWdata, 32'hAB000000);
    checkOutput("sb_err_data", {lastErr, lastResp}, 0);

    // lb / lbu of 0x80 at 0x1001, done in first WAIT cycle (minimum latency)
    applyStimulus(0, 0, 0, 32'h1001, 32'h0, 32'h00008000, 1, 0, 1);
    checkOutput("lb_data", lastResp, 32'hFFFFFF80);
    checkOutput("min_latency", lastLat, 3);
    applyStimulus(0, 0, 1, 32'h1001, 32'h0, 32'h00008000, 2, 1, 0);
    checkOutput("lbu_data", lastResp, 32'h00000080);

    // error paths
    applyStimulus(0, 2, 0, 32'h1002, 32'h0, 32'h0, 1, 2, 1);
    checkOutput("misalign_err", lastErr, 1);
    checkOutput("misalign_no_access", lastPulses, 0);
    applyStimulus(0, 3, 0, 32'h1000, 32'h0, 32'h0, 1, 0, 0);
    checkOutput("size3_err", lastErr, 3);

    // timeout boundary
    applyStimulus(0, 1, 0, 32'h2000, 32'h0, 32'h0, 0, 0, 0);
    checkOutput("timeout_err", lastErr, 2);
    checkOutput("timeout_latency", lastLat, 2 + TIMEOUT);
    applyStimulus(0, 1, 0, 32'h2000, 32'h0, 32'h00001234, TIMEOUT, 0, 0);
    checkOutput("last_cycle_done_err", lastErr, 0);
    checkOutput("last_cycle_done_data", lastResp, 32'h00001234);

    // swapped lw, response held for 5 cycles
    applyStimulus(0, 2, 0, 32'h0, 32'h0, 32'h11223344, 1, 5, 0);
    checkOutput("swap_lw", lastRespS, 32'h44332211);
    checkOutput("plain_lw", lastResp, 32'h11223344);

    // reset pulsed mid-WAIT drops the access
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h3000; mem_done = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("pre_reset_waiting", {req_ready, resp_valid}, 0);
    rstn = 1'b0;
    mem_done = 1'b1;
    @(negedge clk);
    checkResetOutputs();
    @(negedge clk);
    rstn = 1'b1;
    mem_done = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", {req_ready, req_ready_s}, 2'b11);
    checkOutput("post_reset_no_resp", {resp_valid, resp_valid_s}, 0);
    applyStimulus(0, 2, 1, 32'h3004, 32'h0, 32'hCAFEF00D, 3, 0, 0);
    checkOutput("post_reset_lw", lastResp, 32'hCAFEF00D);

    for (int t = 0; t < 150; t++) begin
      st = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sp = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 3) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
      dn = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
      applyStimulus(st, sz, un, ad, $urandom, $urandom, dn, int'($urandom_range(0, 3)), sp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters SHALL be: DATA_W, default 32, memory/register data width, 32 or 64.
REQ-002 ADDR_W, default 32, byte-address width.
REQ-003 ENDIAN_SWAP, default 1, byte-reverses the memory data port when 1.
REQ-004 TIMEOUT, default 1024, maximum cycles to wait for mem_done, minimum 2.
REQ-005 Ports SHALL be: clk  in  1  clock; all logic rising-edge.
REQ-006 rstn  in  1  reset, synchronous, active-low.
REQ-007 req_valid / req_ready  in / out  1  request handshake; transfer when both are 1.
REQ-008 req_store  in  1  1 = store, 0 = load.
REQ-009 req_size  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-010 req_unsigned  in  1  zero-extend the load result.
REQ-011 req_addr  in  ADDR_W  byte address.
REQ-012 req_wdata  in  DATA_W  store data, right-aligned.
REQ-013 resp_valid / resp_ready  out / in  1  response handshake.
REQ-014 resp_data  out  DATA_W  extended load data; 0 for stores and errors.
REQ-015 resp_err  out  2  0 = ok, 1 = misaligned, 2 = timeout, 3 = illegal size.
REQ-016 mem_en  out  1  one-cycle access strobe.
REQ-017 mem_addr  out  ADDR_W  access address.
REQ-018 mem_we  out  DATA_W/8  per-byte write enables.
REQ-019 mem_wdata  out  DATA_W  write data to memory.
REQ-020 mem_rdata  in  DATA_W  read data from memory.
REQ-021 mem_done  in  1  access complete.

Function
REQ-022 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-023 req_ready SHALL be 1 only in IDLE.
REQ-024 On a request transfer, all request fields SHALL be registered.
REQ-025 On a request transfer with no error, the next state SHALL be ISSUE.
REQ-026 On a request transfer with an error, the next state SHALL be RESP with no memory access.
REQ-027 Error priority SHALL be: illegal size (size 3 with DATA_W = 32), then misaligned (addr not a multiple of 2^size).
REQ-028 In ISSUE, mem_en SHALL be 1 for exactly one cycle.
REQ-029 In ISSUE, mem_addr SHALL be req_addr with its low log2(DATA_W/8) bits cleared.
REQ-030 In ISSUE, mem_we SHALL be 0 for loads.
REQ-031 In ISSUE, for stores mem_we SHALL be ((1<<2^size)-1) shifted left by the byte offset.
REQ-032 In ISSUE, mem_wdata SHALL be req_wdata shifted left by 8*offset.
REQ-033 When ENDIAN_SWAP = 1, mem_wdata and mem_rdata SHALL be byte-reversed across DATA_W.
REQ-034 When ENDIAN_SWAP = 1, mem_we SHALL be bit-reversed to match the byte reversal.
REQ-035 The next state after ISSUE SHALL be WAIT; mem_done SHALL be sampled only in WAIT.
REQ-036 In WAIT, a cycle counter SHALL start at 1.
REQ-037 In WAIT, when mem_done = 1, the FSM SHALL capture mem_rdata and go to RESP with resp_err = 0.
REQ-038 In WAIT, if the counter reaches TIMEOUT without mem_done, the FSM SHALL go to RESP with resp_err = 2.
REQ-039 mem_done = 1 arriving on the same cycle the counter reaches TIMEOUT SHALL count as success.
REQ-040 The load result SHALL be the sized field at the byte offset (after any swap).
REQ-041 The load result SHALL be sign-extended unless req_unsigned = 1, then zero-extended.
REQ-042 In RESP, resp_valid SHALL be 1 with resp_data and resp_err held stable until resp_ready = 1.
REQ-043 After the RESP handshake, the next state SHALL be IDLE; minimum request-accept to resp_valid latency SHALL be 3 cycles.
REQ-044 mem_done outside WAIT SHALL be ignored.
REQ-045 Request inputs outside IDLE SHALL be ignored.
REQ-046 Address arithmetic SHALL wrap modulo 2^ADDR_W.

Reset
REQ-047 With rstn = 0 at a clock edge, the FSM SHALL return to IDLE from any state, including WAIT and RESP, and any in-flight response SHALL be dropped.
REQ-048 During reset: req_ready = 0, resp_valid = 0, resp_data = 0, resp_err = 0, mem_en = 0, mem_addr = 0, mem_we = 0, mem_wdata = 0, counter = 0.
REQ-049 On the first cycle after reset release, req_ready SHALL be 1.

Verification (DATA_W = 32, ENDIAN_SWAP = 0 unless noted)
REQ-050 sb at addr 0x1003 with wdata 0xAB -> mem_addr 0x1000, mem_we 4'b1000, mem_wdata 0xAB000000; after mem_done, resp_err 0 and resp_data 0.
REQ-051 lb at 0x1001, mem_rdata 0x00008000 -> resp_data 0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-052 lw at 0x1002 -> no mem_en pulse, resp_valid 2 cycles after accept, resp_err 1; size 3 at 0x1000 -> resp_err 3.
REQ-053 TIMEOUT = 8, lh at 0x2000, mem_done held 0 -> resp_err 2 after 8 WAIT cycles; mem_done on the 8th WAIT cycle -> resp_err 0.
REQ-054 ENDIAN_SWAP = 1, lw at 0x0, mem_rdata 0x11223344 -> resp_data 0x44332211; also hold resp_ready = 0 for 5 cycles -> response stays stable.
REQ-055 rstn = 0 pulsed during WAIT -> all outputs return to reset values, no resp_valid, and the next request completes normally.
